// File: rtl/int_ctrl_pkg.sv
// Shared types and default register map for the external-interrupt controller.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        RISING  = 2'b00,
        FALLING = 2'b01,
        BOTH    = 2'b10,
        LEVEL   = 2'b11
    } int_mode_t;

    localparam int DEF_ADDR_PENDING = 'h20;
    localparam int DEF_ADDR_ENABLE  = 'h21;
    localparam int DEF_ADDR_MODE    = 'h22;
    localparam int DEF_ADDR_CLAIM   = 'h23;

    localparam int CLAIM_VALID_BIT  = 31;

endpackage

// File: rtl/int_trigger.sv
// Per-channel input synchronizer plus mode-selected event detector.
module int_trigger
    import int_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync_reset,
    input  logic       int_i,
    input  logic [1:0] mode_i,
    output logic       event_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d1_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_d1_q <= 1'b0;
        end else if (sync_reset) begin
            sync_q <= '0;
            s_d1_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], int_i};
            s_d1_q <= s;
        end
    end

    // s_d1 tracks regardless of mode, so a mode change alone never fires.
    always_comb begin
        event_o = 1'b0;
        case (int_mode_t'(mode_i))
            RISING:  event_o = s & ~s_d1_q;
            FALLING: event_o = ~s & s_d1_q;
            BOTH:    event_o = s ^ s_d1_q;
            LEVEL:   event_o = s;
            default: event_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/int_ctrl_wb.sv
// External-interrupt controller on the Wishbone dual-port register bus:
// pending/enable/mode registers, priority claim and the int_gen request.
module int_ctrl_wb
    import int_ctrl_pkg::*;
#(
    parameter int NUM_CH           = 8,
    parameter int SYNC_STAGES      = 2,
    parameter int ADDR_BITS        = 12,
    parameter int XLEN             = 32,
    parameter int REG_ADDR_PENDING = DEF_ADDR_PENDING,
    parameter int REG_ADDR_ENABLE  = DEF_ADDR_ENABLE,
    parameter int REG_ADDR_MODE    = DEF_ADDR_MODE,
    parameter int REG_ADDR_CLAIM   = DEF_ADDR_CLAIM,
    parameter bit CLAIM_ON_READ    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_reset,
    input  logic [NUM_CH-1:0]    INTx,
    input  logic                 clear_ext_int,
    input  logic                 WB_RD_STB_I,
    input  logic [ADDR_BITS-1:0] WB_RD_ADR_I,
    output logic [XLEN-1:0]      WB_RD_DAT_O,
    output logic                 WB_RD_ACK_O,
    input  logic                 WB_WR_STB_I,
    input  logic                 WB_WR_WE_I,
    input  logic [XLEN/8-1:0]    WB_WR_SEL_I,
    input  logic [ADDR_BITS-1:0] WB_WR_ADR_I,
    input  logic [XLEN-1:0]      WB_WR_DAT_I,
    output logic                 WB_WR_ACK_O,
    output logic                 int_gen
);

    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   enable_q, enable_d;
    logic [2*NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0]   trig_evt, pend_en, clr_mask, claim_clr;
    logic [XLEN-1:0]     wr_mask, wr_data, rd_dat_q, rd_dat_d, claim_word;
    logic                int_gen_q, rd_ack_q, wr_ack_q;
    logic                claim_valid;
    logic [4:0]          claim_idx;
    logic                wr_pend, wr_en, wr_mode, rd_claim;
    logic                unused_ok;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_trig
        int_trigger #(.SYNC_STAGES(SYNC_STAGES)) u_trig (
            .clk        (clk),
            .reset      (reset),
            .sync_reset (sync_reset),
            .int_i      (INTx[g]),
            .mode_i     (mode_q[2*g +: 2]),
            .event_o    (trig_evt[g])
        );
    end

    assign wr_pend  = WB_WR_WE_I && (WB_WR_ADR_I == ADDR_BITS'(REG_ADDR_PENDING));
    assign wr_en    = WB_WR_WE_I && (WB_WR_ADR_I == ADDR_BITS'(REG_ADDR_ENABLE));
    assign wr_mode  = WB_WR_WE_I && (WB_WR_ADR_I == ADDR_BITS'(REG_ADDR_MODE));
    assign rd_claim = WB_RD_STB_I && (WB_RD_ADR_I == ADDR_BITS'(REG_ADDR_CLAIM));
    assign pend_en  = pending_q & enable_q;
    assign wr_data  = WB_WR_DAT_I & wr_mask;

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < XLEN/8; b++) wr_mask[8*b +: 8] = {8{WB_WR_SEL_I[b]}};
    end

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        claim_valid = 1'b0;
        claim_idx   = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (pend_en[i]) begin
                claim_valid = 1'b1;
                claim_idx   = 5'(i);
            end
        end
        claim_word                  = '0;
        claim_word[CLAIM_VALID_BIT] = claim_valid;
        claim_word[4:0]             = claim_idx;
    end

    always_comb begin
        claim_clr = '0;
        if (CLAIM_ON_READ && rd_claim && claim_valid) claim_clr[claim_idx] = 1'b1;
        clr_mask = claim_clr;
        if (wr_pend)       clr_mask = clr_mask | wr_data[NUM_CH-1:0];
        if (clear_ext_int) clr_mask = '1;
        pending_d = (pending_q & ~clr_mask) | trig_evt;
        enable_d  = wr_en ? ((enable_q & ~wr_mask[NUM_CH-1:0]) | wr_data[NUM_CH-1:0]) : enable_q;
        mode_d    = wr_mode ? ((mode_q & ~wr_mask[2*NUM_CH-1:0]) | wr_data[2*NUM_CH-1:0]) : mode_q;
    end

    always_comb begin
        rd_dat_d = '0;
        if (WB_RD_STB_I) begin
            if (WB_RD_ADR_I == ADDR_BITS'(REG_ADDR_PENDING))     rd_dat_d[NUM_CH-1:0]   = pending_q;
            else if (WB_RD_ADR_I == ADDR_BITS'(REG_ADDR_ENABLE)) rd_dat_d[NUM_CH-1:0]   = enable_q;
            else if (WB_RD_ADR_I == ADDR_BITS'(REG_ADDR_MODE))   rd_dat_d[2*NUM_CH-1:0] = mode_q;
            else if (rd_claim)                                   rd_dat_d               = claim_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            rd_dat_q  <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            int_gen_q <= 1'b0;
        end else if (sync_reset) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            rd_dat_q  <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            int_gen_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            rd_dat_q  <= rd_dat_d;
            rd_ack_q  <= WB_RD_STB_I;
            wr_ack_q  <= WB_WR_WE_I;
            int_gen_q <= |pend_en;
        end
    end

    assign WB_RD_DAT_O = rd_dat_q;
    assign WB_RD_ACK_O = rd_ack_q;
    assign WB_WR_ACK_O = wr_ack_q;
    assign int_gen     = int_gen_q;

    assign unused_ok = ^{WB_WR_STB_I, wr_mask, wr_data};

endmodule

// File: tb/tb_int_ctrl_wb.sv
// Directed and randomized bench for int_ctrl_wb against a delay-line reference model.
module tb_int_ctrl_wb;

    localparam logic [11:0] A_PEND = 12'h020;
    localparam logic [11:0] A_EN   = 12'h021;
    localparam logic [11:0] A_MODE = 12'h022;
    localparam logic [11:0] A_CLM  = 12'h023;

    logic        clk = 1'b0;
    logic        reset = 1'b1, sync_reset = 1'b0, clear_ext_int = 1'b0;
    logic [7:0]  INTx = 8'h00;
    logic        rd_stb = 1'b0, rd_ack, wr_stb = 1'b0, wr_we = 1'b0, wr_ack, int_gen;
    logic [11:0] rd_adr = '0, wr_adr = '0;
    logic [31:0] rd_dat, wr_dat = '0;
    logic [3:0]  wr_sel = '0;

    always #5 clk = ~clk;

    int_ctrl_wb #(.NUM_CH(8), .SYNC_STAGES(2), .CLAIM_ON_READ(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .sync_reset    (sync_reset),
        .INTx          (INTx),
        .clear_ext_int (clear_ext_int),
        .WB_RD_STB_I   (rd_stb),
        .WB_RD_ADR_I   (rd_adr),
        .WB_RD_DAT_O   (rd_dat),
        .WB_RD_ACK_O   (rd_ack),
        .WB_WR_STB_I   (wr_stb),
        .WB_WR_WE_I    (wr_we),
        .WB_WR_SEL_I   (wr_sel),
        .WB_WR_ADR_I   (wr_adr),
        .WB_WR_DAT_I   (wr_dat),
        .WB_WR_ACK_O   (wr_ack),
        .int_gen       (int_gen)
    );

    int n_chk = 0, n_fail = 0;

    // Reference state: registers plus the raw input values seen at past edges.
    logic [7:0]  m_pend = '0, m_en = '0;
    logic [15:0] m_mode = '0;
    logic        m_int = 1'b0;
    logic [7:0]  hist [1:3];
    logic [7:0]  ints_cur = '0;
    logic        sr_cur = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] claim_val(input logic [7:0] pe);
        for (int i = 0; i < 8; i++) if (pe[i]) return 32'h8000_0000 | 32'(i);
        return 32'h0;
    endfunction

    function automatic logic [7:0] events(input logic [15:0] mode, input logic [7:0] s, input logic [7:0] p);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            case (mode[2*i +: 2])
                2'd0: e[i] = s[i] & ~p[i];
                2'd1: e[i] = ~s[i] & p[i];
                2'd2: e[i] = s[i] ^ p[i];
                default: e[i] = s[i];
            endcase
        end
        return e;
    endfunction

    task automatic clear_model();
        m_pend = '0; m_en = '0; m_mode = '0; m_int = 1'b0;
        for (int k = 1; k <= 3; k++) hist[k] = '0;
    endtask

    task automatic cycle(input logic [7:0] ints, input logic rs, input logic [11:0] ra,
                         input logic we, input logic [11:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic cx);
        logic [7:0]  ev, clr, pe;
        logic [31:0] bm, e_rd;
        logic        e_rdack, e_wrack;
        INTx = ints; rd_stb = rs; rd_adr = ra; wr_stb = we; wr_we = we;
        wr_adr = wa; wr_dat = wd; wr_sel = ws; clear_ext_int = cx; sync_reset = sr_cur;
        bm = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
        pe = m_pend & m_en;
        // Two synchronizer stages: s is the input sampled two edges back, s_d1 three.
        ev = events(m_mode, hist[2], hist[3]);
        e_rd = '0;
        if (rs) begin
            if (ra == A_PEND)      e_rd = {24'h0, m_pend};
            else if (ra == A_EN)   e_rd = {24'h0, m_en};
            else if (ra == A_MODE) e_rd = {16'h0, m_mode};
            else if (ra == A_CLM)  e_rd = claim_val(pe);
        end
        clr = '0;
        if (we && wa == A_PEND) clr = clr | (wd[7:0] & bm[7:0]);
        if (cx) clr = 8'hFF;
        if (rs && ra == A_CLM) clr = clr | (pe & (~pe + 8'd1));
        m_int = |pe;
        m_pend = (m_pend & ~clr) | ev;
        if (we && wa == A_EN)   m_en   = (m_en & ~bm[7:0]) | (wd[7:0] & bm[7:0]);
        if (we && wa == A_MODE) m_mode = (m_mode & ~bm[15:0]) | (wd[15:0] & bm[15:0]);
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = ints;
        e_rdack = rs; e_wrack = we;
        if (sr_cur) begin
            clear_model();
            e_rd = '0; e_rdack = 1'b0; e_wrack = 1'b0;
        end
        @(posedge clk);
        #1;
        check("int_gen", {31'h0, int_gen}, {31'h0, m_int});
        check("rd_ack", {31'h0, rd_ack}, {31'h0, e_rdack});
        check("wr_ack", {31'h0, wr_ack}, {31'h0, e_wrack});
        if (rs || sr_cur) check("rd_dat", rd_dat, e_rd);
    endtask

    task automatic rd(input logic [11:0] a);
        cycle(ints_cur, 1'b1, a, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        cycle(ints_cur, 1'b0, 12'h0, 1'b1, a, d, s, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(ints_cur, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_int_gen", {31'h0, int_gen}, 32'h0);
        check("rst_rd_dat", rd_dat, 32'h0);
        check("rst_rd_ack", {31'h0, rd_ack}, 32'h0);
        check("rst_wr_ack", {31'h0, wr_ack}, 32'h0);
        clear_model();
        rd_stb = 1'b0; wr_stb = 1'b0; wr_we = 1'b0; clear_ext_int = 1'b0; INTx = ints_cur;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [11:0] r_ra, r_wa;
    logic [31:0] r_wd;
    logic [3:0]  r_ws;
    logic        r_rs, r_we, r_cx;

    initial begin
        for (int k = 1; k <= 3; k++) hist[k] = '0;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(A_PEND + 12'(a));
            check("reset_reg", rd_dat, 32'h0);
        end

        // Rising-edge latency on ch0
        wr(A_EN, 32'h01, 4'hF);
        ints_cur = 8'h01;
        idle(2);
        rd(A_PEND);
        check("lat_pend_e3_pre", rd_dat, 32'h0);
        rd(A_PEND);
        check("lat_pend", rd_dat, 32'h01);
        check("lat_int_gen", {31'h0, int_gen}, 32'h1);
        wr(A_PEND, 32'h01, 4'hF);
        check("w1c_int_hold", {31'h0, int_gen}, 32'h1);
        idle(1);
        check("w1c_int_drop", {31'h0, int_gen}, 32'h0);

        // Falling on ch0, both edges on ch1
        ints_cur = 8'h00;
        idle(4);
        wr(A_PEND, 32'hFF, 4'hF);
        wr(A_MODE, 32'h0009, 4'hF);
        wr(A_EN, 32'h03, 4'hF);
        ints_cur = 8'h03;
        idle(4);
        rd(A_PEND);
        check("both_rise", rd_dat, 32'h02);
        wr(A_PEND, 32'h02, 4'hF);
        ints_cur = 8'h00;
        idle(4);
        rd(A_PEND);
        check("fall_and_both", rd_dat, 32'h03);
        wr(A_PEND, 32'h03, 4'hF);
        rd(A_PEND);
        check("fb_cleared", rd_dat, 32'h0);

        // Level mode on ch2 with set-wins against W1C
        wr(A_MODE, 32'h0039, 4'hF);
        wr(A_EN, 32'h07, 4'hF);
        ints_cur = 8'h04;
        idle(4);
        wr(A_PEND, 32'h04, 4'hF);
        rd(A_PEND);
        check("level_set_wins", rd_dat, 32'h04);
        ints_cur = 8'h00;
        idle(4);
        wr(A_PEND, 32'h04, 4'hF);
        rd(A_PEND);
        check("level_cleared", rd_dat, 32'h0);

        // Claim priority and claim-on-read
        wr(A_MODE, 32'h0, 4'hF);
        wr(A_EN, 32'hFF, 4'hF);
        ints_cur = 8'h0C;
        idle(4);
        rd(A_PEND);
        check("claim_pend", rd_dat, 32'h0C);
        rd(A_CLM);
        check("claim_first", rd_dat, 32'h8000_0002);
        rd(A_CLM);
        check("claim_second", rd_dat, 32'h8000_0003);
        rd(A_CLM);
        check("claim_empty", rd_dat, 32'h0);
        ints_cur = 8'h00;
        idle(3);
        ints_cur = 8'h0C;
        idle(4);
        wr(A_EN, 32'h0, 4'hF);
        rd(A_CLM);
        check("claim_disabled", rd_dat, 32'h0);

        // Byte select and clear_ext_int
        wr(A_EN, 32'hFFFF_FFFF, 4'b0001);
        rd(A_EN);
        check("sel_byte0", rd_dat, 32'hFF);
        wr(A_EN, 32'h0, 4'b0010);
        rd(A_EN);
        check("sel_byte1_only", rd_dat, 32'hFF);
        check("pre_clr_int", {31'h0, int_gen}, 32'h1);
        cycle(ints_cur, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1);
        idle(1);
        check("clr_ext_int_drop", {31'h0, int_gen}, 32'h0);
        rd(A_PEND);
        check("clr_ext_pend", rd_dat, 32'h0);

        // Async reset mid-burst
        ints_cur = 8'h00;
        idle(3);
        ints_cur = 8'h01;
        idle(5);
        check("burst_int", {31'h0, int_gen}, 32'h1);
        cycle(ints_cur, 1'b1, A_PEND, 1'b1, A_EN, 32'hFF, 4'hF, 1'b0);
        ints_cur = 8'h00;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(A_PEND + 12'(a));
            check("post_rst_reg", rd_dat, 32'h0);
        end
        idle(4);
        check("post_rst_quiet", {31'h0, int_gen}, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) ints_cur = 8'($urandom);
            r_rs = 1'($urandom_range(0, 1));
            r_ra = A_PEND + 12'($urandom_range(0, 4));
            r_we = ($urandom_range(0, 3) == 0);
            r_wa = A_PEND + 12'($urandom_range(0, 3));
            r_wd = $urandom;
            r_ws = 4'($urandom);
            r_cx = ($urandom_range(0, 31) == 0);
            cycle(ints_cur, r_rs, r_ra, r_we, r_wa, r_wd, r_ws, r_cx);
        end

        // Synchronous clear
        sr_cur = 1'b1;
        cycle(ints_cur, 1'b1, A_EN, 1'b1, A_EN, 32'hFF, 4'hF, 1'b0);
        sr_cur = 1'b0;
        ints_cur = 8'h00;
        for (int a = 0; a < 3; a++) begin
            rd(A_PEND + 12'(a));
            check("sync_rst_reg", rd_dat, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
